// File: rtl/quadra_coef_loader.sv
// rtl/quadra_coef_loader.sv - streams a/b/c coefficient triples into a segment table and serves registered reads
module quadra_coef_loader #(
    parameter int ENTRIES = 128,
    parameter int IDX_W   = 7,
    parameter int COEF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [COEF_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_x1,
    output logic [COEF_W-1:0] rd_a,
    output logic [COEF_W-1:0] rd_b,
    output logic [COEF_W-1:0] rd_c,
    output logic              rd_valid,
    output logic              table_valid,
    output logic [COEF_W-1:0] csum
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_ENTRY = IDX_W'(ENTRIES - 1);

    state_t            state;
    logic [IDX_W-1:0]  entry_cnt;
    logic [1:0]        field_cnt;

    logic [COEF_W-1:0] mem_a [ENTRIES];
    logic [COEF_W-1:0] mem_b [ENTRIES];
    logic [COEF_W-1:0] mem_c [ENTRIES];

    // An abort in the same cycle as a handshake discards that word.
    logic accept;
    logic last_word;
    assign accept    = s_ready && s_valid && !abort;
    assign last_word = accept && (entry_cnt == LAST_ENTRY) && (field_cnt == 2'd2);

    // Load sequencing: state, word/field counters, running checksum and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_ready     <= 1'b0;
            table_valid <= 1'b0;
            entry_cnt   <= '0;
            field_cnt   <= 2'd0;
            csum        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= LOAD;
                        s_ready     <= 1'b1;
                        table_valid <= 1'b0;
                        entry_cnt   <= '0;
                        field_cnt   <= 2'd0;
                        csum        <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state       <= IDLE;
                        s_ready     <= 1'b0;
                        table_valid <= 1'b0;
                    end else if (accept) begin
                        csum <= csum + s_data;
                        if (field_cnt == 2'd2) begin
                            field_cnt <= 2'd0;
                            entry_cnt <= entry_cnt + 1'b1;
                        end else begin
                            field_cnt <= field_cnt + 2'd1;
                        end
                        if (last_word) begin
                            state       <= DONE;
                            s_ready     <= 1'b0;
                            table_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    s_ready     <= 1'b0;
                    table_valid <= 1'b0;
                end
            endcase
        end
    end

    // Coefficient storage is deliberately not reset; word order per entry is a, b, c.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (field_cnt)
                2'd0:    mem_a[entry_cnt] <= s_data;
                2'd1:    mem_b[entry_cnt] <= s_data;
                default: mem_c[entry_cnt] <= s_data;
            endcase
        end
    end

    // Registered read port; a same-cycle write to the same slot returns the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_a     <= '0;
            rd_b     <= '0;
            rd_c     <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_a <= mem_a[rd_x1];
                rd_b <= mem_b[rd_x1];
                rd_c <= mem_c[rd_x1];
            end
        end
    end

endmodule

// File: tb/tb_quadra_coef_loader.sv
// tb/tb_quadra_coef_loader.sv - randomized self-checking bench for quadra_coef_loader
module tb_quadra_coef_loader;

    localparam int ENTRIES = 128;
    localparam int IDX_W   = 7;
    localparam int COEF_W  = 32;
    localparam int NWORDS  = 3 * ENTRIES;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [COEF_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_x1;
    logic [COEF_W-1:0] rd_a;
    logic [COEF_W-1:0] rd_b;
    logic [COEF_W-1:0] rd_c;
    logic              rd_valid;
    logic              table_valid;
    logic [COEF_W-1:0] csum;

    quadra_coef_loader #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .COEF_W(COEF_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .rd_en(rd_en), .rd_x1(rd_x1), .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
        .rd_valid(rd_valid), .table_valid(table_valid), .csum(csum)
    );

    always #5 clk = ~clk;

    // Reference model: flat table of triples plus checksum of the current load
    logic [COEF_W-1:0] m_tab [ENTRIES][3];
    logic [COEF_W-1:0] m_csum;
    int                pass_cnt = 0;
    int                total    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_word(input int k, input logic [COEF_W-1:0] w);
        m_tab[k / 3][k % 3] = w;
        m_csum = m_csum + w;
    endtask

    task automatic begin_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_csum = '0;
    endtask

    // dmode: 0 word=k, 1 all ones, 2 random; vmode: 0 always valid, 1 toggle starting low, 2 random
    task automatic feed(input int n, input int dmode, input int vmode,
                        output int done, output int cycles, output int ready_err);
        logic [COEF_W-1:0] w;
        logic v;
        done = 0; cycles = 0; ready_err = 0;
        while (done < n && cycles < 4000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cycles % 2) == 1;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            case (dmode)
                0:       w = COEF_W'(done);
                1:       w = '1;
                default: w = $urandom;
            endcase
            if (s_ready !== 1'b1) ready_err++;
            s_valid = v;
            s_data  = v ? w : $urandom;
            tick();
            if (v) begin
                model_word(done, w);
                done++;
            end
            cycles++;
        end
        s_valid = 1'b0;
    endtask

    task automatic read_entry(input int x, output logic [3*COEF_W-1:0] obs, output logic v);
        rd_en = 1'b1;
        rd_x1 = IDX_W'(x);
        tick();
        rd_en = 1'b0;
        obs = {rd_a, rd_b, rd_c};
        v = rd_valid;
    endtask

    task automatic test_reset();
        total++;
        if ({s_ready, table_valid, rd_valid, csum, rd_a, rd_b, rd_c} !== '0) begin
            $display("FAIL reset_outputs: got ready=%b tv=%b rv=%b csum=%h a=%h b=%h c=%h want all 0",
                     s_ready, table_valid, rd_valid, csum, rd_a, rd_b, rd_c);
        end else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total++;
        if ({s_ready, table_valid, csum} !== '0) begin
            $display("FAIL reset_idle: got ready=%b tv=%b csum=%h want 0", s_ready, table_valid, csum);
        end else pass_cnt++;
    endtask

    task automatic test_full_load();
        int done, cycles, rerr;
        logic [3*COEF_W-1:0] obs;
        logic v;
        begin_load();
        total++;
        if (s_ready !== 1'b1 || table_valid !== 1'b0) begin
            $display("FAIL full_enter_load: got ready=%b tv=%b want 1 0", s_ready, table_valid);
        end else pass_cnt++;
        feed(NWORDS, 0, 0, done, cycles, rerr);
        total++;
        if (done != NWORDS || rerr != 0) begin
            $display("FAIL full_stream: got words=%0d ready_errs=%0d want %0d 0", done, rerr, NWORDS);
        end else pass_cnt++;
        total++;
        if (s_ready !== 1'b0 || table_valid !== 1'b1 || csum !== 32'h00011F40) begin
            $display("FAIL full_done: got ready=%b tv=%b csum=%h want 0 1 00011f40", s_ready, table_valid, csum);
        end else pass_cnt++;
        read_entry(5, obs, v);
        total++;
        if (obs !== {32'd15, 32'd16, 32'd17} || v !== 1'b1) begin
            $display("FAIL full_read5: got %h v=%b want 15,16,17 v=1", obs, v);
        end else pass_cnt++;
        tick();
        total++;
        if (rd_valid !== 1'b0 || {rd_a, rd_b, rd_c} !== {32'd15, 32'd16, 32'd17}) begin
            $display("FAIL full_read_hold: got v=%b %h want v=0 held", rd_valid, {rd_a, rd_b, rd_c});
        end else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int done, cycles, rerr, x;
        logic [3*COEF_W-1:0] obs;
        logic v;
        begin_load();
        feed(NWORDS, 0, 1, done, cycles, rerr);
        total++;
        if (cycles != 768 || rerr != 0 || done != NWORDS) begin
            $display("FAIL bp_cycles: got cycles=%0d ready_errs=%0d words=%0d want 768 0 %0d", cycles, rerr, done, NWORDS);
        end else pass_cnt++;
        total++;
        if (table_valid !== 1'b1 || csum !== 32'h00011F40 || csum !== m_csum) begin
            $display("FAIL bp_done: got tv=%b csum=%h want 1 00011f40", table_valid, csum);
        end else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            x = $urandom_range(0, ENTRIES - 1);
            read_entry(x, obs, v);
            total++;
            if (obs !== {m_tab[x][0], m_tab[x][1], m_tab[x][2]} || v !== 1'b1) begin
                $display("FAIL bp_read[%0d]: got %h v=%b want %h", x, obs, v, {m_tab[x][0], m_tab[x][1], m_tab[x][2]});
            end else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        int done, cycles, rerr;
        logic [3*COEF_W-1:0] obs;
        logic v;
        begin_load();
        feed(100, 0, 0, done, cycles, rerr);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (s_ready !== 1'b0 || table_valid !== 1'b0 || csum !== 32'h00001356 || csum !== m_csum) begin
            $display("FAIL abort_idle: got ready=%b tv=%b csum=%h want 0 0 00001356", s_ready, table_valid, csum);
        end else pass_cnt++;
        read_entry(10, obs, v);
        total++;
        if (obs !== {m_tab[10][0], m_tab[10][1], m_tab[10][2]}) begin
            $display("FAIL abort_partial: got %h want %h", obs, {m_tab[10][0], m_tab[10][1], m_tab[10][2]});
        end else pass_cnt++;
        begin_load();
        total++;
        if (s_ready !== 1'b1 || csum !== '0) begin
            $display("FAIL abort_restart: got ready=%b csum=%h want 1 0", s_ready, csum);
        end else pass_cnt++;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        total++;
        if (s_ready !== 1'b0 || table_valid !== 1'b0) begin
            $display("FAIL abort_over_start: got ready=%b tv=%b want 0 0", s_ready, table_valid);
        end else pass_cnt++;
    endtask

    task automatic test_wrap();
        int done, cycles, rerr;
        logic [3*COEF_W-1:0] obs;
        logic v;
        begin_load();
        feed(NWORDS, 1, 2, done, cycles, rerr);
        total++;
        if (table_valid !== 1'b1 || csum !== 32'hFFFFFE80 || rerr != 0) begin
            $display("FAIL wrap_csum: got tv=%b csum=%h ready_errs=%0d want 1 fffffe80 0", table_valid, csum, rerr);
        end else pass_cnt++;
        read_entry(127, obs, v);
        total++;
        if (obs !== {96{1'b1}} || v !== 1'b1) begin
            $display("FAIL wrap_read127: got %h v=%b want all ones", obs, v);
        end else pass_cnt++;
    endtask

    task automatic test_collision();
        logic [COEF_W-1:0] old_a;
        begin_load();
        old_a   = m_tab[0][0];
        s_valid = 1'b1;
        s_data  = 32'hA5A5A5A5;
        rd_en   = 1'b1;
        rd_x1   = '0;
        tick();
        s_valid = 1'b0;
        model_word(0, 32'hA5A5A5A5);
        total++;
        if (rd_a !== old_a || rd_valid !== 1'b1 || table_valid !== 1'b0) begin
            $display("FAIL collide_old: got a=%h v=%b tv=%b want %h 1 0", rd_a, rd_valid, table_valid, old_a);
        end else pass_cnt++;
        tick();
        rd_en = 1'b0;
        total++;
        if (rd_a !== 32'hA5A5A5A5 || csum !== m_csum) begin
            $display("FAIL collide_new: got a=%h csum=%h want a5a5a5a5 %h", rd_a, csum, m_csum);
        end else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int done, cycles, rerr, x;
        logic [3*COEF_W-1:0] obs;
        logic v;
        read_entry(5, obs, v);
        begin_load();
        feed(50, 2, 0, done, cycles, rerr);
        rst_n = 1'b0;
        #2;
        m_csum = '0;
        total++;
        if ({s_ready, table_valid, rd_valid, csum, rd_a, rd_b, rd_c} !== '0) begin
            $display("FAIL rst_mid_async: got ready=%b tv=%b rv=%b csum=%h a=%h want all 0",
                     s_ready, table_valid, rd_valid, csum, rd_a);
        end else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        s_data  = $urandom;
        tick();
        tick();
        s_valid = 1'b0;
        total++;
        if (s_ready !== 1'b0 || csum !== '0) begin
            $display("FAIL rst_needs_start: got ready=%b csum=%h want 0 0", s_ready, csum);
        end else pass_cnt++;
        begin_load();
        feed(NWORDS, 2, 2, done, cycles, rerr);
        total++;
        if (done != NWORDS || table_valid !== 1'b1 || csum !== m_csum) begin
            $display("FAIL rst_reload: got words=%0d tv=%b csum=%h want %0d 1 %h", done, table_valid, csum, NWORDS, m_csum);
        end else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            x = $urandom_range(0, ENTRIES - 1);
            read_entry(x, obs, v);
            total++;
            if (obs !== {m_tab[x][0], m_tab[x][1], m_tab[x][2]}) begin
                $display("FAIL reload_read[%0d]: got %h want %h", x, obs, {m_tab[x][0], m_tab[x][1], m_tab[x][2]});
            end else pass_cnt++;
        end
    endtask

    task automatic test_random_reads();
        logic [3*COEF_W-1:0] exp_d;
        logic exp_v, en;
        int x;
        exp_d = {rd_a, rd_b, rd_c};
        for (int i = 0; i < 24; i++) begin
            en = ($urandom_range(0, 1) == 1);
            x  = $urandom_range(0, ENTRIES - 1);
            rd_en = en;
            rd_x1 = IDX_W'(x);
            tick();
            exp_v = en;
            if (en) exp_d = {m_tab[x][0], m_tab[x][1], m_tab[x][2]};
            total++;
            if ({rd_a, rd_b, rd_c} !== exp_d || rd_valid !== exp_v) begin
                $display("FAIL rand_read[%0d]: got %h v=%b want %h v=%b", i, {rd_a, rd_b, rd_c}, rd_valid, exp_d, exp_v);
            end else pass_cnt++;
        end
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        s_data = '0; s_valid = 1'b0; rd_en = 1'b0; rd_x1 = '0;
        m_csum = '0;
        for (int e = 0; e < ENTRIES; e++)
            for (int f = 0; f < 3; f++) m_tab[e][f] = 'x;
        tick();
        tick();
        test_reset();
        test_full_load();
        test_backpressure();
        test_abort();
        test_wrap();
        test_collision();
        test_reset_mid_load();
        test_random_reads();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
